// File: rtl/tuser_out_arb_if.sv
// Bus bundle for tuser_out_arb: two AXIS+tuple requesters in, one shared AXIS+tuple port out.
interface tuser_out_arb_if #(
   parameter int unsigned DATA_W  = 256,
   parameter int unsigned KEEP_W  = 32,
   parameter int unsigned TUPLE_W = 128
);
   logic                s0_avalid;
   logic                s0_aready;
   logic [DATA_W-1:0]   s0_adata;
   logic [KEEP_W-1:0]   s0_akeep;
   logic                s0_atlast;
   logic                s0_valid;
   logic [TUPLE_W-1:0]  s0_data;

   logic                s1_avalid;
   logic                s1_aready;
   logic [DATA_W-1:0]   s1_adata;
   logic [KEEP_W-1:0]   s1_akeep;
   logic                s1_atlast;
   logic                s1_valid;
   logic [TUPLE_W-1:0]  s1_data;

   logic                m_avalid;
   logic                m_aready;
   logic [DATA_W-1:0]   m_adata;
   logic [KEEP_W-1:0]   m_akeep;
   logic                m_atlast;
   logic                m_valid;
   logic [TUPLE_W-1:0]  m_data;

   // Arbiter side
   modport slave (
      input  s0_avalid, s0_adata, s0_akeep, s0_atlast, s0_valid, s0_data,
      output s0_aready,
      input  s1_avalid, s1_adata, s1_akeep, s1_atlast, s1_valid, s1_data,
      output s1_aready,
      output m_avalid, m_adata, m_akeep, m_atlast, m_valid, m_data,
      input  m_aready
   );

   // Environment side (requesters + downstream consumer)
   modport master (
      output s0_avalid, s0_adata, s0_akeep, s0_atlast, s0_valid, s0_data,
      input  s0_aready,
      output s1_avalid, s1_adata, s1_akeep, s1_atlast, s1_valid, s1_data,
      input  s1_aready,
      input  m_avalid, m_adata, m_akeep, m_atlast, m_valid, m_data,
      output m_aready
   );
endinterface

// File: rtl/tuser_out_arb.sv
// Two-source packet arbiter: round-robin per packet, one-cycle tuple pulse, then
// unmodified beat passthrough from the granted source up to and including tlast.
module tuser_out_arb #(
   parameter int unsigned DATA_W  = 256,
   parameter int unsigned KEEP_W  = 32,
   parameter int unsigned TUPLE_W = 128,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               tarb_aclk,
   input  logic               tarb_arst,
   tuser_out_arb_if.slave     bus,
   output logic [2:0]         dbg_state,
   output logic               dbg_grant,
   output logic [CNT_W-1:0]   dbg_pkt_cnt0,
   output logic [CNT_W-1:0]   dbg_pkt_cnt1
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'b001,
      ST_TUPLE = 3'b010,
      ST_DATA  = 3'b100
   } state_e;

   state_e              state_q, state_d;
   logic                grant_q, grant_d;
   logic                rr_q, rr_d;
   logic [TUPLE_W-1:0]  tuple_q, tuple_d;
   logic [CNT_W-1:0]    cnt0_q, cnt0_d;
   logic [CNT_W-1:0]    cnt1_q, cnt1_d;

   logic                sel_avalid, sel_atlast;
   logic [DATA_W-1:0]   sel_adata;
   logic [KEEP_W-1:0]   sel_akeep;

   logic                m_avalid_c, m_atlast_c, m_valid_c;
   logic [DATA_W-1:0]   m_adata_c;
   logic [KEEP_W-1:0]   m_akeep_c;
   logic                s0_aready_c, s1_aready_c;

   // Beat mux for the currently granted source
   always_comb begin
      sel_avalid = grant_q ? bus.s1_avalid : bus.s0_avalid;
      sel_adata  = grant_q ? bus.s1_adata  : bus.s0_adata;
      sel_akeep  = grant_q ? bus.s1_akeep  : bus.s0_akeep;
      sel_atlast = grant_q ? bus.s1_atlast : bus.s0_atlast;
   end

   always_ff @(posedge tarb_aclk or negedge tarb_arst) begin
      if (!tarb_arst) begin
         state_q <= ST_IDLE;
         grant_q <= 1'b0;
         rr_q    <= 1'b0;
         tuple_q <= '0;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         tuple_q <= tuple_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_d        = rr_q;
      tuple_d     = tuple_q;
      cnt0_d      = cnt0_q;
      cnt1_d      = cnt1_q;
      m_avalid_c  = 1'b0;
      m_adata_c   = '0;
      m_akeep_c   = '0;
      m_atlast_c  = 1'b0;
      m_valid_c   = 1'b0;
      s0_aready_c = 1'b0;
      s1_aready_c = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // Contention resolved by rr pointer; a lone requester wins outright
            if (bus.s0_valid || bus.s1_valid) begin
               grant_d = (bus.s0_valid && bus.s1_valid) ? rr_q : bus.s1_valid;
               tuple_d = grant_d ? bus.s1_data : bus.s0_data;
               state_d = ST_TUPLE;
            end
         end
         ST_TUPLE: begin
            m_valid_c = 1'b1;
            state_d   = ST_DATA;
         end
         ST_DATA: begin
            m_avalid_c  = sel_avalid;
            m_adata_c   = sel_adata;
            m_akeep_c   = sel_akeep;
            m_atlast_c  = sel_atlast;
            s0_aready_c = ~grant_q & bus.m_aready;
            s1_aready_c =  grant_q & bus.m_aready;
            if (sel_avalid && bus.m_aready && sel_atlast) begin
               state_d = ST_IDLE;
               rr_d    = ~grant_q;
               if (grant_q) cnt1_d = cnt1_q + CNT_W'(1);
               else         cnt0_d = cnt0_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.m_avalid  = m_avalid_c;
   assign bus.m_adata   = m_adata_c;
   assign bus.m_akeep   = m_akeep_c;
   assign bus.m_atlast  = m_atlast_c;
   assign bus.m_valid   = m_valid_c;
   assign bus.m_data    = tuple_q;
   assign bus.s0_aready = s0_aready_c;
   assign bus.s1_aready = s1_aready_c;

   assign dbg_state    = state_q;
   assign dbg_grant    = grant_q;
   assign dbg_pkt_cnt0 = cnt0_q;
   assign dbg_pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_tuser_out_arb.sv
// Directed bench for tuser_out_arb: negedge monitor logs tuples/beats, directed
// packets are compared against hand-computed tuples, beats, grant order and counters.
module tb_tuser_out_arb;
   localparam int unsigned DATA_W  = 256;
   localparam int unsigned KEEP_W  = 32;
   localparam int unsigned TUPLE_W = 128;
   localparam int unsigned CNT_W   = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tuser_out_arb_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .TUPLE_W(TUPLE_W)) bus ();

   logic [2:0]        dbg_state;
   logic              dbg_grant;
   logic [CNT_W-1:0]  cnt0, cnt1;

   tuser_out_arb #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .TUPLE_W(TUPLE_W), .CNT_W(CNT_W)) dut (
      .tarb_aclk    (clk),
      .tarb_arst    (rst_n),
      .bus          (bus),
      .dbg_state    (dbg_state),
      .dbg_grant    (dbg_grant),
      .dbg_pkt_cnt0 (cnt0),
      .dbg_pkt_cnt1 (cnt1)
   );

   logic               s_avalid [2];
   logic               s_atlast [2];
   logic               s_valid  [2];
   logic [DATA_W-1:0]  s_adata  [2];
   logic [KEEP_W-1:0]  s_akeep  [2];
   logic [TUPLE_W-1:0] s_data   [2];
   logic               maready;
   logic               abort;

   assign bus.s0_avalid = s_avalid[0];
   assign bus.s0_atlast = s_atlast[0];
   assign bus.s0_valid  = s_valid[0];
   assign bus.s0_adata  = s_adata[0];
   assign bus.s0_akeep  = s_akeep[0];
   assign bus.s0_data   = s_data[0];
   assign bus.s1_avalid = s_avalid[1];
   assign bus.s1_atlast = s_atlast[1];
   assign bus.s1_valid  = s_valid[1];
   assign bus.s1_adata  = s_adata[1];
   assign bus.s1_akeep  = s_akeep[1];
   assign bus.s1_data   = s_data[1];
   assign bus.m_aready  = maready;

   int unsigned n_vec = 0;
   int unsigned n_miss = 0;

   // Output log, sampled mid-cycle
   int unsigned        cyc = 0;
   int unsigned        order_err = 0;
   int unsigned        aready_cnt [2];
   logic               in_pkt = 1'b0;
   logic [TUPLE_W-1:0] q_tup  [$];
   logic               q_gnt  [$];
   int unsigned        q_tcyc [$];
   logic [DATA_W-1:0]  q_bd   [$];
   logic [KEEP_W-1:0]  q_bk   [$];
   logic               q_bl   [$];
   int unsigned        q_lcyc [$];

   initial begin
      aready_cnt[0] = 0;
      aready_cnt[1] = 0;
   end

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (!rst_n) in_pkt = 1'b0;
      if (bus.s0_aready) aready_cnt[0] = aready_cnt[0] + 1;
      if (bus.s1_aready) aready_cnt[1] = aready_cnt[1] + 1;
      if (bus.m_valid) begin
         if (in_pkt) order_err = order_err + 1;
         in_pkt = 1'b1;
         q_tup.push_back(bus.m_data);
         q_gnt.push_back(dbg_grant);
         q_tcyc.push_back(cyc);
      end
      if (bus.m_avalid && maready) begin
         if (!in_pkt) order_err = order_err + 1;
         q_bd.push_back(bus.m_adata);
         q_bk.push_back(bus.m_akeep);
         q_bl.push_back(bus.m_atlast);
         if (bus.m_atlast) begin
            in_pkt = 1'b0;
            q_lcyc.push_back(cyc);
         end
      end
   end

   task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      n_vec = n_vec + 1;
      if (got !== exp) begin
         n_miss = n_miss + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " m_avalid"},  DATA_W'(bus.m_avalid),  DATA_W'(0));
      chk({tag, " m_valid"},   DATA_W'(bus.m_valid),   DATA_W'(0));
      chk({tag, " m_adata"},   bus.m_adata,            DATA_W'(0));
      chk({tag, " m_akeep"},   DATA_W'(bus.m_akeep),   DATA_W'(0));
      chk({tag, " m_atlast"},  DATA_W'(bus.m_atlast),  DATA_W'(0));
      chk({tag, " m_data"},    DATA_W'(bus.m_data),    DATA_W'(0));
      chk({tag, " s0_aready"}, DATA_W'(bus.s0_aready), DATA_W'(0));
      chk({tag, " s1_aready"}, DATA_W'(bus.s1_aready), DATA_W'(0));
      chk({tag, " dbg_state"}, DATA_W'(dbg_state),     DATA_W'(3'b001));
      chk({tag, " dbg_grant"}, DATA_W'(dbg_grant),     DATA_W'(0));
      chk({tag, " cnt0"},      DATA_W'(cnt0),          DATA_W'(0));
      chk({tag, " cnt1"},      DATA_W'(cnt1),          DATA_W'(0));
   endtask

   task automatic clear_src();
      for (int s = 0; s < 2; s++) begin
         s_avalid[s] = 1'b0; s_atlast[s] = 1'b0; s_valid[s] = 1'b0;
         s_adata[s]  = '0;   s_akeep[s]  = '0;   s_data[s]  = '0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_src();
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Requester: raise tuple request, present beats, drop request after first accept
   task automatic send_pkt(input int src, input logic [TUPLE_W-1:0] tup, input int n,
                           input logic [DATA_W-1:0] dbase, input logic [KEEP_W-1:0] kbase);
      logic ok;
      int   guard;
      s_valid[src] = 1'b1;
      s_data[src]  = tup;
      for (int i = 0; i < n && !abort; i++) begin
         s_avalid[src] = 1'b1;
         s_adata[src]  = dbase + DATA_W'(i);
         s_akeep[src]  = kbase + KEEP_W'(i);
         s_atlast[src] = (i == n - 1);
         ok = 1'b0;
         guard = 0;
         while (!ok && !abort && guard < 200) begin
            @(negedge clk);
            ok = (src == 0) ? bus.s0_aready : bus.s1_aready;
            @(posedge clk); #1;
            guard++;
         end
         if (!abort && guard >= 200) begin
            chk($sformatf("src%0d beat wait", src), DATA_W'(ok), DATA_W'(1));
            break;
         end
         s_valid[src] = 1'b0;
      end
      s_valid[src]  = 1'b0;
      s_avalid[src] = 1'b0;
      s_atlast[src] = 1'b0;
   endtask

   int unsigned rd_t = 0;
   int unsigned rd_b = 0;

   task automatic sync_logs();
      rd_t = q_tup.size();
      rd_b = q_bd.size();
   endtask

   task automatic expect_pkt(input string tag, input logic [TUPLE_W-1:0] tup, input int n,
                             input logic [DATA_W-1:0] dbase, input logic [KEEP_W-1:0] kbase);
      logic avail;
      avail = (q_tup.size() > rd_t) && (q_bd.size() >= rd_b + n);
      chk({tag, " logged"}, DATA_W'(avail), DATA_W'(1));
      if (!avail) return;
      chk({tag, " tuple"}, DATA_W'(q_tup[rd_t]), DATA_W'(tup));
      rd_t++;
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s b%0d data", tag, i), q_bd[rd_b], dbase + DATA_W'(i));
         chk($sformatf("%s b%0d keep", tag, i), DATA_W'(q_bk[rd_b]), DATA_W'(kbase + KEEP_W'(i)));
         chk($sformatf("%s b%0d last", tag, i), DATA_W'(q_bl[rd_b]), DATA_W'(i == n - 1));
         rd_b++;
      end
   endtask

   function automatic logic [TUPLE_W-1:0] t3_tup(input int s, input int k);
      return TUPLE_W'(32'h3000_0000 + 32'(s * 256 + k));
   endfunction
   function automatic logic [DATA_W-1:0] t3_dat(input int s, input int k);
      return DATA_W'(32'hD000_0000 + 32'(s * 65536 + k * 256));
   endfunction
   function automatic logic [KEEP_W-1:0] t3_keep(input int s, input int k);
      return KEEP_W'(32'hA000_0000 + 32'(s * 4096 + k * 16));
   endfunction
   function automatic int t3_len(input int s, input int k);
      return 1 + ((s + k) % 3);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", n_miss);
      $fatal(1);
   end

   initial begin
      int unsigned g0, e0, a1, l0, t0, b0;
      logic        done4;
      logic        pat [6];
      int          g;
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;
      abort = 1'b0;
      maready = 1'b0;
      clear_src();

      // Reset with random inputs: outputs must stay quiet
      for (int r = 0; r < 3; r++) begin
         @(posedge clk); #1;
         for (int s = 0; s < 2; s++) begin
            s_avalid[s] = 1'($urandom); s_atlast[s] = 1'($urandom); s_valid[s] = 1'($urandom);
            s_adata[s]  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            s_akeep[s]  = $urandom;
            s_data[s]   = {$urandom, $urandom, $urandom, $urandom};
         end
         maready = 1'($urandom);
         #3;
         chk_reset_outputs($sformatf("rst%0d", r));
      end
      clear_src();
      maready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      sync_logs();
      repeat (5) begin @(posedge clk); #1; end
      chk("idle no grant state", DATA_W'(dbg_state), DATA_W'(3'b001));
      chk("idle no tuple", DATA_W'(q_tup.size()), DATA_W'(rd_t));

      // Single src0 packet
      sync_logs();
      a1 = aready_cnt[1];
      e0 = order_err;
      send_pkt(0, TUPLE_W'(20'h44444), 3, DATA_W'(20'h22222), KEEP_W'(20'h33333));
      repeat (2) begin @(posedge clk); #1; end
      expect_pkt("t2", TUPLE_W'(20'h44444), 3, DATA_W'(20'h22222), KEEP_W'(20'h33333));
      chk("t2 tuple pulses", DATA_W'(q_tup.size()), DATA_W'(rd_t));
      chk("t2 extra beats", DATA_W'(q_bd.size()), DATA_W'(rd_b));
      chk("t2 cnt0", DATA_W'(cnt0), DATA_W'(1));
      chk("t2 cnt1", DATA_W'(cnt1), DATA_W'(0));
      chk("t2 s1_aready", DATA_W'(aready_cnt[1] - a1), DATA_W'(0));
      chk("t2 order", DATA_W'(order_err - e0), DATA_W'(0));
      chk("t2 grant", DATA_W'(dbg_grant), DATA_W'(0));

      // Both sources, 4 back-to-back packets each: strict alternation from rr=0
      do_reset();
      sync_logs();
      g0 = rd_t;
      e0 = order_err;
      fork
         for (int k = 0; k < 4; k++) send_pkt(0, t3_tup(0, k), t3_len(0, k), t3_dat(0, k), t3_keep(0, k));
         for (int k = 0; k < 4; k++) send_pkt(1, t3_tup(1, k), t3_len(1, k), t3_dat(1, k), t3_keep(1, k));
      join
      repeat (2) begin @(posedge clk); #1; end
      chk("t3 tuple count", DATA_W'(q_tup.size() - g0), DATA_W'(8));
      for (int j = 0; j < 8; j++)
         if (g0 + j < q_gnt.size())
            chk($sformatf("t3 grant%0d", j), DATA_W'(q_gnt[g0 + j]), DATA_W'(j % 2));
      for (int k = 0; k < 4; k++) begin
         expect_pkt($sformatf("t3 s0p%0d", k), t3_tup(0, k), t3_len(0, k), t3_dat(0, k), t3_keep(0, k));
         expect_pkt($sformatf("t3 s1p%0d", k), t3_tup(1, k), t3_len(1, k), t3_dat(1, k), t3_keep(1, k));
      end
      chk("t3 cnt0", DATA_W'(cnt0), DATA_W'(4));
      chk("t3 cnt1", DATA_W'(cnt1), DATA_W'(4));
      chk("t3 order", DATA_W'(order_err - e0), DATA_W'(0));

      // 5-beat packet under a stalling downstream
      do_reset();
      sync_logs();
      b0 = rd_b;
      a1 = aready_cnt[1];
      done4 = 1'b0;
      fork
         begin
            send_pkt(0, TUPLE_W'(32'h5555_0004), 5, DATA_W'(32'h4000_0000), KEEP_W'(32'hF000_0000));
            done4 = 1'b1;
         end
         begin
            for (int c = 0; c < 150 && !done4; c++) begin
               maready = pat[c % 6];
               @(posedge clk); #1;
            end
            maready = 1'b1;
         end
      join
      repeat (2) begin @(posedge clk); #1; end
      chk("t4 beat count", DATA_W'(q_bd.size() - b0), DATA_W'(5));
      expect_pkt("t4", TUPLE_W'(32'h5555_0004), 5, DATA_W'(32'h4000_0000), KEEP_W'(32'hF000_0000));
      chk("t4 s1_aready", DATA_W'(aready_cnt[1] - a1), DATA_W'(0));
      chk("t4 cnt0", DATA_W'(cnt0), DATA_W'(1));

      // Single-beat src1 packet, src0 waiting behind it
      sync_logs();
      t0 = rd_t;
      l0 = q_lcyc.size();
      fork
         send_pkt(1, TUPLE_W'(32'h5555_0105), 1, DATA_W'(32'h5100_0000), KEEP_W'(32'h0000_00FF));
         begin
            repeat (2) begin @(posedge clk); #1; end
            send_pkt(0, TUPLE_W'(32'h5555_0005), 2, DATA_W'(32'h5000_0000), KEEP_W'(32'h0000_0F00));
         end
      join
      repeat (2) begin @(posedge clk); #1; end
      expect_pkt("t5 s1", TUPLE_W'(32'h5555_0105), 1, DATA_W'(32'h5100_0000), KEEP_W'(32'h0000_00FF));
      expect_pkt("t5 s0", TUPLE_W'(32'h5555_0005), 2, DATA_W'(32'h5000_0000), KEEP_W'(32'h0000_0F00));
      if (q_tcyc.size() > t0 + 1 && q_lcyc.size() > l0)
         chk("t5 tuple gap", DATA_W'(q_tcyc[t0 + 1] - q_lcyc[l0]), DATA_W'(2));
      else
         chk("t5 gap logged", DATA_W'(q_tcyc.size()), DATA_W'(t0 + 2));
      chk("t5 cnt0", DATA_W'(cnt0), DATA_W'(2));
      chk("t5 cnt1", DATA_W'(cnt1), DATA_W'(1));

      // Async reset during beat 2 of a 4-beat packet
      sync_logs();
      b0 = rd_b;
      fork
         send_pkt(0, TUPLE_W'(32'h5555_0006), 4, DATA_W'(32'h6000_0000), KEEP_W'(32'h0000_6000));
         begin
            g = 0;
            while (q_bd.size() <= b0 && g < 100) begin @(posedge clk); g++; end
            chk("t6 beat1 seen", DATA_W'(q_bd.size() > b0), DATA_W'(1));
            #3;
            chk("t6 beat2 presented", DATA_W'(bus.m_avalid), DATA_W'(1));
            abort = 1'b1;
            rst_n = 1'b0;
            #1;
            chk_reset_outputs("t6 async");
            repeat (2) begin @(posedge clk); #1; end
         end
      join
      clear_src();
      abort = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      sync_logs();
      send_pkt(0, TUPLE_W'(32'h5555_0016), 3, DATA_W'(32'h6100_0000), KEEP_W'(32'h0000_6100));
      repeat (2) begin @(posedge clk); #1; end
      expect_pkt("t6 fresh", TUPLE_W'(32'h5555_0016), 3, DATA_W'(32'h6100_0000), KEEP_W'(32'h0000_6100));
      chk("t6 cnt0", DATA_W'(cnt0), DATA_W'(1));
      chk("t6 cnt1", DATA_W'(cnt1), DATA_W'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
